sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sdram_arbiter_if.sv | 32 +++
 rtl/sdram_arbiter_rr.sv | 21 ++
 rtl/sdram_arbiter.sv | 141 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions used by the arbiter and the SDRAM controller.
// Holds the default bus widths and the arbiter FSM state encoding.
package sdram_pkg;

    // 13 row + 2 bank + 9 column + 1 byte-select bits
    localparam int SDRAM_ADDR_WIDTH  = 25;
    localparam int SDRAM_DATA_WIDTH  = 16;
    // Wide enough to hold a burst length of 64
    localparam int SDRAM_BURST_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Burst-capable memory-mapped bus between a requester and a responder.
// Ports (by modport):
//   master : drives address, burstcount, read, write, writedata, byteenable;
//            receives waitrequest, readdata, readdatavalid.
//   slave  : the mirror image of master.
interface sdram_arbiter_if
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH  = SDRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = SDRAM_DATA_WIDTH,
    parameter int BURST_WIDTH = SDRAM_BURST_WIDTH
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [BURST_WIDTH-1:0]  burstcount;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_arbiter_rr.sv
// Two-way round-robin selector.
// Ports:
//   req    : request vector, bit N set when master N wants the bus.
//   last   : index of the master served most recently.
//   winner : index of the master to serve next (0 when nobody requests).
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);
    // A sole requester always wins; on a tie the master not served last wins.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end
endmodule

// File: rtl/sdram_arbiter.sv
// Two-master burst arbiter in front of a single SDRAM controller port.
// Ports:
//   clk, arst  : clock and asynchronous active-high reset.
//   init_done  : controller initialisation complete; gates leaving IDLE only.
//   m0, m1     : requester buses (slave side of the interface).
//   s          : bus to the SDRAM controller (master side of the interface).
//   grant      : one-hot current owner, 2'b00 while idle or arbitrating.
// A burst is owned end to end: address and burstcount are latched at
// arbitration, the owner's command/data lines pass straight through, and the
// bus is released when the beat counter reaches its last beat.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH  = SDRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = SDRAM_DATA_WIDTH,
    parameter int BURST_WIDTH = SDRAM_BURST_WIDTH
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             init_done,
    sdram_arbiter_if.slave   m0,
    sdram_arbiter_if.slave   m1,
    sdram_arbiter_if.master  s,
    output logic [1:0]       grant
);
    arb_state_e              state_q;
    logic                    owner_q;
    logic                    last_q;
    logic [1:0]              grant_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BURST_WIDTH-1:0]  burst_q;
    logic [BURST_WIDTH-1:0]  beats_q;

    logic [1:0]              req_s;
    logic                    winner_s;
    logic                    win_read_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;
    logic [BURST_WIDTH-1:0]  win_burst_s;
    logic [BURST_WIDTH-1:0]  win_len_s;
    logic                    own_read_s;
    logic                    own_write_s;
    logic [DATA_WIDTH-1:0]   own_wdata_s;
    logic [DATA_WIDTH/8-1:0] own_be_s;
    logic                    beat_fire_s;

    assign req_s = {m1.read | m1.write, m0.read | m0.write};

    rr_arbiter2 u_rr (
        .req    (req_s),
        .last   (last_q),
        .winner (winner_s)
    );

    // Winner-side view, sampled only in ARB
    assign win_read_s  = winner_s ? m1.read       : m0.read;
    assign win_addr_s  = winner_s ? m1.address    : m0.address;
    assign win_burst_s = winner_s ? m1.burstcount : m0.burstcount;
    // A zero burstcount still moves one word
    assign win_len_s   = (win_burst_s == '0) ? BURST_WIDTH'(1) : win_burst_s;

    // Owner-side live signals forwarded while a burst is in flight
    assign own_read_s  = owner_q ? m1.read       : m0.read;
    assign own_write_s = owner_q ? m1.write      : m0.write;
    assign own_wdata_s = owner_q ? m1.writedata  : m0.writedata;
    assign own_be_s    = owner_q ? m1.byteenable : m0.byteenable;

    // One burst beat completes: a returned read word, or an accepted write word
    always_comb begin
        beat_fire_s = 1'b0;
        case (state_q)
            ST_READ:  beat_fire_s = s.readdatavalid;
            ST_WRITE: beat_fire_s = s.write & ~s.waitrequest;
            default:  beat_fire_s = 1'b0;
        endcase
    end

    // Arbitration FSM with latched owner, address, burst length and beat counter
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
            addr_q  <= '0;
            burst_q <= '0;
            beats_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (init_done && (req_s != 2'b00)) begin
                        state_q <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (req_s != 2'b00) begin
                        owner_q <= winner_s;
                        last_q  <= winner_s;
                        grant_q <= winner_s ? 2'b10 : 2'b01;
                        addr_q  <= win_addr_s;
                        burst_q <= win_len_s;
                        beats_q <= win_len_s;
                        state_q <= win_read_s ? ST_READ : ST_WRITE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (beat_fire_s) begin
                        beats_q <= beats_q - BURST_WIDTH'(1);
                        if (beats_q == BURST_WIDTH'(1)) begin
                            state_q <= ST_IDLE;
                            grant_q <= 2'b00;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign s.address    = addr_q;
    assign s.burstcount = burst_q;
    // Commands reach the controller only from the state matching the burst type
    assign s.read       = (state_q == ST_READ)  & own_read_s;
    assign s.write      = (state_q == ST_WRITE) & own_write_s;
    assign s.writedata  = own_wdata_s;
    assign s.byteenable = own_be_s;

    // grant_q clears asynchronously, so a reset cuts off stalls and beats at once
    assign m0.waitrequest   = grant_q[0] ? s.waitrequest : 1'b1;
    assign m1.waitrequest   = grant_q[1] ? s.waitrequest : 1'b1;
    assign m0.readdatavalid = grant_q[0] & (state_q == ST_READ) & s.readdatavalid;
    assign m1.readdatavalid = grant_q[1] & (state_q == ST_READ) & s.readdatavalid;
    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;

    assign grant = grant_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_arbiter;
    logic       clk = 1'b0;
    logic       arst;
    logic       init_done;
    logic [1:0] grant;

    sdram_arbiter_if m0_if ();
    sdram_arbiter_if m1_if ();
    sdram_arbiter_if s_if ();

    sdram_arbiter dut (
        .clk       (clk),
        .arst      (arst),
        .init_done (init_done),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [15:0] rmem [256];   // reference memory: what each word should hold
    logic [15:0] smem [256];   // memory behind the modelled SDRAM controller
    logic [15:0] exp0 [$];
    logic [15:0] exp1 [$];
    logic [1:0]  ghist [$];
    logic [1:0]  gprev;
    int          wait_mode = 0;
    bit          rdv_gaps = 1'b0;
    int          s_wr_beats = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    function automatic logic get_wait(input int n);
        return (n == 0) ? m0_if.waitrequest : m1_if.waitrequest;
    endfunction

    function automatic int qsize(input int n);
        return (n == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic set_cmd(input int n, input logic rd, input logic wr, input logic [7:0] w,
                           input logic [6:0] bc, input logic [15:0] d);
        if (n == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = {16'd0, w, 1'b0};
            m0_if.burstcount = bc; m0_if.writedata = d; m0_if.byteenable = 2'b11;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = {16'd0, w, 1'b0};
            m1_if.burstcount = bc; m1_if.writedata = d; m1_if.byteenable = 2'b11;
        end
    endtask

    // Expected read data comes from the reference memory at issue time
    task automatic push_exp(input int n, input logic [7:0] w, input logic [6:0] bc);
        int nb;
        logic [7:0] a;
        nb = (bc == 7'd0) ? 1 : int'(bc);
        for (int i = 0; i < nb; i++) begin
            a = w + 8'(i);
            if (n == 0) exp0.push_back(rmem[a]);
            else        exp1.push_back(rmem[a]);
        end
    endtask

    // Returns at the negedge before the accepting posedge; ok=0 on timeout
    task automatic wait_accept(input int n, output bit ok);
        int t;
        t = 0;
        ok = 1'b1;
        forever begin
            @(negedge clk);
            if (!get_wait(n)) break;
            t++;
            if (t > 3000) begin
                fail_now("accept_timeout");
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int n);
        int t;
        t = 0;
        while (qsize(n) != 0) begin
            @(posedge clk); #1;
            t++;
            if (t > 3000) begin
                fail_now("drain_timeout");
                if (n == 0) exp0.delete(); else exp1.delete();
                break;
            end
        end
    endtask

    task automatic do_read(input int n, input logic [7:0] w, input logic [6:0] bc);
        bit ok;
        push_exp(n, w, bc);
        set_cmd(n, 1'b1, 1'b0, w, bc, 16'd0);
        wait_accept(n, ok);
        @(posedge clk); #1;
        set_cmd(n, 1'b0, 1'b0, w, bc, 16'd0);
        if (ok) wait_drain(n);
        else if (n == 0) exp0.delete(); else exp1.delete();
    endtask

    task automatic do_write(input int n, input logic [7:0] w, input logic [6:0] bc);
        int nb;
        bit ok;
        logic [15:0] d;
        nb = (bc == 7'd0) ? 1 : int'(bc);
        for (int i = 0; i < nb; i++) begin
            d = 16'($urandom);
            set_cmd(n, 1'b0, 1'b1, w, bc, d);
            wait_accept(n, ok);
            if (ok) rmem[w + 8'(i)] = d;
            @(posedge clk); #1;
            if (!ok) break;
        end
        set_cmd(n, 1'b0, 1'b0, w, bc, 16'd0);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst = 1'b0;
    endtask

    task automatic rand_master(input int n);
        logic [7:0] w;
        logic [6:0] bc;
        repeat (25) begin
            bc = 7'($urandom_range(0, 6));
            w  = 8'(n * 128 + int'($urandom_range(0, 100)));
            if ($urandom_range(0, 1) == 1) do_read(n, w, bc);
            else                           do_write(n, w, bc);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    // SDRAM controller model: accepts commands at negedge, drives responses after posedge
    initial begin : slave_model
        logic [7:0] rq_base [$];
        int         rq_len [$];
        logic [7:0] rbase;
        logic [7:0] wbase;
        int         rleft;
        int         ridx;
        int         wleft;
        int         widx;
        bit         tog;
        rleft = 0; ridx = 0; wleft = 0; widx = 0; tog = 1'b0; rbase = 8'd0; wbase = 8'd0;
        s_if.waitrequest = 1'b0;
        s_if.readdatavalid = 1'b0;
        s_if.readdata = 16'd0;
        forever begin
            @(negedge clk);
            if (arst) begin
                rq_base.delete(); rq_len.delete(); rleft = 0; wleft = 0;
            end else begin
                if (s_if.read && !s_if.waitrequest) begin
                    rq_base.push_back(s_if.address[8:1]);
                    rq_len.push_back(int'(s_if.burstcount));
                end
                if (s_if.write && !s_if.waitrequest) begin
                    if (wleft <= 0) begin
                        wbase = s_if.address[8:1]; wleft = int'(s_if.burstcount); widx = 0;
                    end
                    smem[wbase + 8'(widx)] = s_if.writedata;
                    widx++; wleft--; s_wr_beats++;
                end
            end
            @(posedge clk); #1;
            tog = ~tog;
            case (wait_mode)
                0:       s_if.waitrequest = 1'b0;
                1:       s_if.waitrequest = tog;
                default: s_if.waitrequest = ($urandom_range(0, 2) == 0);
            endcase
            if (rleft <= 0 && rq_base.size() > 0) begin
                rbase = rq_base.pop_front(); rleft = rq_len.pop_front(); ridx = 0;
            end
            if (!arst && rleft > 0 && (!rdv_gaps || $urandom_range(0, 3) != 0)) begin
                s_if.readdatavalid = 1'b1;
                s_if.readdata = smem[rbase + 8'(ridx)];
                ridx++; rleft--;
            end else begin
                s_if.readdatavalid = 1'b0;
                s_if.readdata = 16'($urandom);
            end
        end
    end

    // Scoreboard monitor: every delivered beat must match the head of its master's queue
    initial begin : monitor
        gprev = 2'b00;
        forever begin
            @(negedge clk);
            if (arst) begin
                chk("rst_rdv0", {31'd0, m0_if.readdatavalid}, 32'd0);
                chk("rst_rdv1", {31'd0, m1_if.readdatavalid}, 32'd0);
                gprev = 2'b00;
            end else begin
                if (m0_if.readdatavalid) begin
                    if (exp0.size() == 0) begin
                        total++; bad++;
                        $display("FAIL m0_extra_beat: got %0h expected no beat", m0_if.readdata);
                    end else chk("m0_rdata", {16'd0, m0_if.readdata}, {16'd0, exp0.pop_front()});
                end
                if (m1_if.readdatavalid) begin
                    if (exp1.size() == 0) begin
                        total++; bad++;
                        $display("FAIL m1_extra_beat: got %0h expected no beat", m1_if.readdata);
                    end else chk("m1_rdata", {16'd0, m1_if.readdata}, {16'd0, exp1.pop_front()});
                end
                if (grant != gprev && grant != 2'b00) ghist.push_back(grant);
                gprev = grant;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit ok;
        int sw0;
        arst = 1'b1;
        init_done = 1'b0;
        set_cmd(0, 1'b0, 1'b0, 8'd0, 7'd0, 16'd0);
        set_cmd(1, 1'b0, 1'b0, 8'd0, 7'd0, 16'd0);
        for (int i = 0; i < 256; i++) begin
            rmem[i] = 16'(i * 37) ^ 16'h5a5a;
            smem[i] = 16'(i * 37) ^ 16'h5a5a;
        end
        @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_m0_wait", {31'd0, m0_if.waitrequest}, 32'd1);
        chk("rst_m1_wait", {31'd0, m1_if.waitrequest}, 32'd1);
        chk("rst_s_read", {31'd0, s_if.read}, 32'd0);
        chk("rst_s_write", {31'd0, s_if.write}, 32'd0);
        @(posedge clk); #1;
        arst = 1'b0;

        // Request held while init_done is low, then released
        push_exp(0, 8'd10, 7'd2);
        set_cmd(0, 1'b1, 1'b0, 8'd10, 7'd2, 16'd0);
        repeat (4) begin
            @(negedge clk);
            chk("noinit_m0_wait", {31'd0, m0_if.waitrequest}, 32'd1);
            chk("noinit_s_read", {31'd0, s_if.read}, 32'd0);
        end
        @(posedge clk); #1;
        init_done = 1'b1;
        @(negedge clk); chk("init_c0_s_read", {31'd0, s_if.read}, 32'd0);
        @(negedge clk); chk("init_c1_s_read", {31'd0, s_if.read}, 32'd0);
        chk("arb_m0_wait", {31'd0, m0_if.waitrequest}, 32'd1);
        @(negedge clk); chk("init_c2_s_read", {31'd0, s_if.read}, 32'd1);
        chk("init_grant", {30'd0, grant}, 32'd1);
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 1'b0, 8'd10, 7'd2, 16'd0);
        wait_drain(0);

        // Simultaneous reads after reset: m0 first, then m1
        do_reset();
        ghist.delete();
        fork
            do_read(0, 8'd20, 7'd4);
            do_read(1, 8'd150, 7'd4);
        join
        chk("rr_hist_len", ghist.size(), 32'd2);
        chk("rr_first", {30'd0, (ghist.size() > 0) ? ghist[0] : 2'b11}, 32'd1);
        chk("rr_second", {30'd0, (ghist.size() > 1) ? ghist[1] : 2'b11}, 32'd2);

        // 8-beat write with a toggling stall, then read it back
        wait_mode = 1;
        sw0 = s_wr_beats;
        do_write(1, 8'd160, 7'd8);
        chk("wr8_beats", s_wr_beats - sw0, 32'd8);
        @(negedge clk); chk("wr8_grant_idle", {30'd0, grant}, 32'd0);
        @(posedge clk); #1;
        wait_mode = 0;
        do_read(1, 8'd160, 7'd8);

        // Zero burstcount moves exactly one word
        do_read(0, 8'd30, 7'd0);
        @(negedge clk); chk("bc0_grant_idle", {30'd0, grant}, 32'd0);
        @(posedge clk); #1;

        // Reset three beats into a 16-beat read
        push_exp(0, 8'd40, 7'd16);
        set_cmd(0, 1'b1, 1'b0, 8'd40, 7'd16, 16'd0);
        wait_accept(0, ok);
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 1'b0, 8'd40, 7'd16, 16'd0);
        for (int t = 0; t < 200 && exp0.size() > 13; t++) begin @(posedge clk); #1; end
        chk("midrst_beats_seen", exp0.size(), 32'd13);
        arst = 1'b1;
        @(negedge clk);
        chk("midrst_grant", {30'd0, grant}, 32'd0);
        chk("midrst_m0_rdv", {31'd0, m0_if.readdatavalid}, 32'd0);
        exp0.delete();
        @(posedge clk); #1;
        arst = 1'b0;
        ghist.delete();
        do_read(1, 8'd170, 7'd3);
        chk("postrst_grant", {30'd0, (ghist.size() > 0) ? ghist[0] : 2'b11}, 32'd2);

        // Read and write together from one master: read wins
        push_exp(0, 8'd50, 7'd2);
        set_cmd(0, 1'b1, 1'b1, 8'd50, 7'd2, 16'hdead);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            chk("rw_s_write", {31'd0, s_if.write}, 32'd0);
            if (!m0_if.waitrequest) break;
        end
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 1'b0, 8'd50, 7'd2, 16'd0);
        wait_drain(0);

        // Random traffic from both masters on disjoint regions
        wait_mode = 2;
        rdv_gaps = 1'b1;
        fork
            rand_master(0);
            rand_master(1);
        join
        repeat (4) begin @(posedge clk); #1; end
        chk("final_q0", exp0.size(), 32'd0);
        chk("final_q1", exp1.size(), 32'd0);
        chk("final_grant", {30'd0, grant}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
